// File: rtl/cs_ovr_queue.sv
// cs_ovr_queue: ModRM/prefix override of a decoded control word,
// buffered in a small FIFO whose head can be replayed for REP strings.
module cs_ovr_queue #(
  parameter int CW_W   = 227,
  parameter int DEPTH  = 4,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  input  logic [1:0]        in_size,
  input  logic [1:0]        in_imm_sz,
  input  logic [2:0]        in_r1,
  input  logic [2:0]        in_r2,
  input  logic [2:0]        in_s1,
  input  logic [2:0]        in_s3,
  input  logic [1:0]        in_m1_rw,
  input  logic [5:0]        in_flags,
  input  logic [8:0]        in_pref,
  input  logic [7:0]        in_b2,
  input  logic [7:0]        in_b3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic [1:0]        out_size,
  output logic [1:0]        out_imm_sz,
  output logic [2:0]        out_r1,
  output logic [2:0]        out_r2,
  output logic [2:0]        out_s1,
  output logic [2:0]        out_s3,
  output logic [1:0]        out_m1_rw,
  output logic              out_rep,
  output logic              out_first,
  output logic [ITER_W-1:0] out_iter,
  input  logic              rep_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = PW + 1;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic [1:0]      size;
    logic [1:0]      imm;
    logic [2:0]      r1;
    logic [2:0]      r2;
    logic [2:0]      s1;
    logic [2:0]      s3;
    logic [1:0]      rw;
    logic            rep;
  } ent_t;

  typedef enum logic {S_HEAD, S_REPL} st_t;

  ent_t              r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CNW-1:0]    r_cnt;
  st_t               r_st;
  st_t               w_st_nx;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] w_iter_nx;
  ent_t              w_ent;
  ent_t              w_head;
  logic [7:0]        w_m;
  logic              w_regm;
  logic              w_mod;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;

  assign w_mod  = in_flags[5];
  assign w_m    = in_flags[4] ? in_b3 : in_b2;
  assign w_regm = (w_m[7:6] == 2'b11);

  always_comb begin
    w_ent      = '0;
    w_ent.cw   = in_cw;
    w_ent.rep  = in_pref[8];
    w_ent.size = in_size;
    w_ent.imm  = in_imm_sz;
    if (in_pref[7] && in_size == 2'b10) begin
      w_ent.size = 2'b01;
      w_ent.imm  = 2'b01;
    end
    w_ent.r1 = (w_mod && in_flags[3]) ? w_m[5:3] : in_r1;
    w_ent.s3 = (w_mod && w_regm && in_flags[2]) ? w_m[5:3] : in_s3;
    w_ent.rw = in_m1_rw;
    w_ent.r2 = in_r2;
    if (w_mod && w_regm && (|in_flags[1:0])) begin
      w_ent.rw = 2'b00;
      w_ent.r2 = w_m[2:0];
    end
    w_ent.s1 = in_s1;
    if (w_mod && in_pref[6]) begin
      // scan downward so the lowest set bit wins
      w_ent.s1 = 3'd0;
      for (int k = 5; k >= 0; k--)
        if (in_pref[k]) w_ent.s1 = 3'(k);
    end
  end

  assign in_ready  = (r_cnt != CNW'(DEPTH));
  assign out_valid = (r_cnt != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_hs      = out_valid && out_ready;
  assign w_head    = out_valid ? r_mem[r_rd] : '0;

  always_comb begin
    w_st_nx   = r_st;
    w_iter_nx = r_iter;
    w_pop     = 1'b0;
    if (w_hs) begin
      if (!w_head.rep || rep_done) begin
        w_pop     = 1'b1;
        w_st_nx   = S_HEAD;
        w_iter_nx = '0;
      end else if (r_st == S_HEAD) begin
        w_st_nx   = S_REPL;
        w_iter_nx = ITER_W'(1);
      end else if (r_iter != '1) begin
        w_iter_nx = r_iter + ITER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_st   <= S_HEAD;
      r_iter <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNW'(1);
      r_st   <= w_st_nx;
      r_iter <= w_iter_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr] <= w_ent;
  end

  assign out_cw     = w_head.cw;
  assign out_size   = w_head.size;
  assign out_imm_sz = w_head.imm;
  assign out_r1     = w_head.r1;
  assign out_r2     = w_head.r2;
  assign out_s1     = w_head.s1;
  assign out_s3     = w_head.s3;
  assign out_m1_rw  = w_head.rw;
  assign out_rep    = w_head.rep;
  assign out_first  = (r_st == S_HEAD);
  assign out_iter   = r_iter;

endmodule

// File: tb/tb_cs_ovr_queue.sv
// tb_cs_ovr_queue: scoreboard bench for the override queue,
// expected entries modelled at push, checked at output handshake.
module tb_cs_ovr_queue;
  localparam int CW = 227;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_cw = '0;
  logic [1:0]    in_size = '0, in_imm_sz = '0, in_m1_rw = '0;
  logic [2:0]    in_r1 = '0, in_r2 = '0, in_s1 = '0, in_s3 = '0;
  logic [5:0]    in_flags = '0;
  logic [8:0]    in_pref = '0;
  logic [7:0]    in_b2 = '0, in_b3 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_cw;
  logic [1:0]    out_size, out_imm_sz, out_m1_rw;
  logic [2:0]    out_r1, out_r2, out_s1, out_s3;
  logic          out_rep, out_first;
  logic [7:0]    out_iter;
  logic          rep_done = 1'b0;

  cs_ovr_queue #(.CW_W(CW), .DEPTH(4), .ITER_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cw(in_cw), .in_size(in_size), .in_imm_sz(in_imm_sz),
    .in_r1(in_r1), .in_r2(in_r2), .in_s1(in_s1), .in_s3(in_s3),
    .in_m1_rw(in_m1_rw), .in_flags(in_flags), .in_pref(in_pref),
    .in_b2(in_b2), .in_b3(in_b3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cw(out_cw), .out_size(out_size), .out_imm_sz(out_imm_sz),
    .out_r1(out_r1), .out_r2(out_r2), .out_s1(out_s1), .out_s3(out_s3),
    .out_m1_rw(out_m1_rw), .out_rep(out_rep), .out_first(out_first),
    .out_iter(out_iter), .rep_done(rep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cw;
    logic [1:0]    size, imm, rw;
    logic [2:0]    r1, r2, s1, s3;
    logic          rep;
  } exp_t;

  exp_t sb[$];
  logic [7:0] m_iter = '0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic [7:0] m;
    logic rm, md;
    md = in_flags[5];
    m  = in_flags[4] ? in_b3 : in_b2;
    rm = m[7] & m[6];
    e.cw  = in_cw;
    e.rep = in_pref[8];
    if (in_pref[7] && in_size == 2'b10) begin
      e.size = 2'b01; e.imm = 2'b01;
    end else begin
      e.size = in_size; e.imm = in_imm_sz;
    end
    e.r1 = (md && in_flags[3]) ? m[5:3] : in_r1;
    e.s3 = (md && rm && in_flags[2]) ? m[5:3] : in_s3;
    if (md && rm && in_flags[1:0] != 2'b00) begin
      e.rw = 2'b00; e.r2 = m[2:0];
    end else begin
      e.rw = in_m1_rw; e.r2 = in_r2;
    end
    e.s1 = in_s1;
    if (md && in_pref[6]) begin
      e.s1 = 3'd0;
      for (int k = 0; k < 6; k++)
        if (in_pref[k]) begin e.s1 = 3'(k); break; end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      m_iter = '0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underrun", 1, 0);
      else begin
        chk("cw",    out_cw,     sb[0].cw);
        chk("size",  out_size,   sb[0].size);
        chk("imm",   out_imm_sz, sb[0].imm);
        chk("r1",    out_r1,     sb[0].r1);
        chk("r2",    out_r2,     sb[0].r2);
        chk("s1",    out_s1,     sb[0].s1);
        chk("s3",    out_s3,     sb[0].s3);
        chk("m1_rw", out_m1_rw,  sb[0].rw);
        chk("rep",   out_rep,    sb[0].rep);
        chk("first", out_first,  m_iter == 8'd0);
        chk("iter",  out_iter,   m_iter);
        if (sb[0].rep && !rep_done) begin
          if (m_iter != 8'hFF) m_iter = m_iter + 8'd1;
        end else begin
          void'(sb.pop_front());
          m_iter = '0;
        end
      end
    end
  end

  task automatic rnd_fields(input logic rep);
    for (int k = 0; k < CW; k++) in_cw[k] = 1'($urandom % 2);
    in_size   = 2'($urandom);  in_imm_sz = 2'($urandom);
    in_r1     = 3'($urandom);  in_r2     = 3'($urandom);
    in_s1     = 3'($urandom);  in_s3     = 3'($urandom);
    in_m1_rw  = 2'($urandom);  in_flags  = 6'($urandom);
    in_pref   = {rep, 8'($urandom)};
    in_b2     = 8'($urandom);  in_b3     = 8'($urandom);
  endtask

  task automatic push_one();
    bit acc = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; sb.push_back(model()); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 300 && sb.size() != 0; n++) begin
      rep_done = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rep_done  = 1'b0;
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_iter",  out_iter, 0);
    chk("rst_r1",    out_r1, 0);
    rnd_fields(1'b0);
    push_one();
    chk("lat_valid", out_valid, 1);
    drain();

    rnd_fields(1'b0);
    in_flags = 6'b101101; in_b2 = 8'hD9;
    push_one();
    chk("ovr_r1", out_r1, 3);
    chk("ovr_s3", out_s3, 3);
    chk("ovr_rw", out_m1_rw, 0);
    chk("ovr_r2", out_r2, 1);
    drain();

    rnd_fields(1'b0);
    in_flags = 6'b100000; in_size = 2'b10; in_imm_sz = 2'b10;
    in_pref = 9'b0_1_1_001000;
    push_one();
    chk("sz_size", out_size, 1);
    chk("sz_imm",  out_imm_sz, 1);
    chk("seg_s1",  out_s1, 3);
    drain();

    rnd_fields(1'b0);
    in_flags = 6'b100000; in_pref = 9'b0_0_1_010100;
    push_one();
    chk("seg_low", out_s1, 2);
    drain();

    for (int i = 0; i < 4; i++) begin
      rnd_fields(1'b0);
      push_one();
      chk("fill_ready", in_ready, i < 3);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_ready", in_ready, 1);
    drain();

    rnd_fields(1'b1);
    push_one();
    for (int k = 0; k < 4; k++) begin
      chk("rep_iter",  out_iter, k);
      chk("rep_first", out_first, k == 0);
      out_ready = 1'b1;
      rep_done  = (k == 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rep_done  = 1'b0;
    chk("rep_popped", out_valid, 0);

    rnd_fields(1'b1); push_one();
    rnd_fields(1'b0); push_one();
    rnd_fields(1'b0); push_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("repl_first", out_first, 0);
    chk("repl_iter",  out_iter, 1);
    rnd_fields(1'b0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_iter",  out_iter, 0);
    chk("fl_first", out_first, 1);
    @(posedge clk); #1;
    chk("fl_ignore", out_valid, 0);

    for (int r = 0; r < 6; r++) begin
      out_ready = (r % 2 == 1);
      rep_done  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        rnd_fields(1'($urandom % 4 == 0));
        push_one();
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
